// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch port, the load/store port, the shared memory bus and the
// status outputs of mem_port_arbiter.
//   master : the arbiter itself. It consumes requests and drives the memory bus.
//   slave  : the surroundings. These are the IF stage, the MEM stage and the
//            external memory.
// Signals:
//   if_req/if_addr -> if_rdata/if_ack                  instruction fetch
//   dm_rd/dm_wr/dm_addr/dm_wdata/dm_be -> dm_rdata/dm_ack   load/store
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be <- mem_rdata/mem_ready  memory
//   stall_o, err_o                                     pipeline status
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_ack;

    logic                  dm_rd;
    logic                  dm_wr;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [BE_WIDTH-1:0]   dm_be;
    logic [DATA_WIDTH-1:0] dm_rdata;
    logic                  dm_ack;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [BE_WIDTH-1:0]   mem_be;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    logic                  stall_o;
    logic                  err_o;

    modport master (
        input  if_req, if_addr,
        output if_rdata, if_ack,
        input  dm_rd, dm_wr, dm_addr, dm_wdata, dm_be,
        output dm_rdata, dm_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ready,
        output stall_o, err_o
    );

    modport slave (
        output if_req, if_addr,
        input  if_rdata, if_ack,
        output dm_rd, dm_wr, dm_addr, dm_wdata, dm_be,
        input  dm_rdata, dm_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ready,
        input  stall_o, err_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between instruction fetch (IF) and load/store
// (DM).
// - DM has priority over IF. After MAX_DM_BURST consecutive DM grants made
//   while IF was waiting, IF gets the next grant.
// - Each transaction is latched at grant. It waits for mem_ready and then
//   pulses the requester's ack for one cycle.
// - A transaction is aborted after TIMEOUT cycles without mem_ready. The
//   abort still pulses the ack, returns rdata = 0 and sets err_o.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mem_port_arbiter_if.master. It carries the fetch port, the
//          load/store port, the memory bus, stall_o and err_o.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_DM_BURST = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.master bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int BURST_W  = $clog2(MAX_DM_BURST + 1);
    localparam int TMO_W    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_IFETCH, ST_DACC} state_t;

    state_t                state_reg,     state_next;
    logic                  mem_we_reg,    mem_we_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg,  mem_addr_next;
    logic [DATA_WIDTH-1:0] mem_wdata_reg, mem_wdata_next;
    logic [BE_WIDTH-1:0]   mem_be_reg,    mem_be_next;
    logic [DATA_WIDTH-1:0] if_rdata_reg,  if_rdata_next;
    logic [DATA_WIDTH-1:0] dm_rdata_reg,  dm_rdata_next;
    logic                  if_ack_reg,    if_ack_next;
    logic                  dm_ack_reg,    dm_ack_next;
    logic                  err_reg,       err_next;
    logic [BURST_W-1:0]    burst_reg,     burst_next;
    logic [TMO_W-1:0]      tmo_reg,       tmo_next;

    logic                  dm_any;
    logic                  grant_dm;
    logic                  grant_if;
    logic                  done_ok;
    logic                  done_tmo;
    logic [DATA_WIDTH-1:0] resp_data;

    assign dm_any = bus.dm_rd | bus.dm_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_be_reg    <= '0;
            if_rdata_reg  <= '0;
            dm_rdata_reg  <= '0;
            if_ack_reg    <= 1'b0;
            dm_ack_reg    <= 1'b0;
            err_reg       <= 1'b0;
            burst_reg     <= '0;
            tmo_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_be_reg    <= mem_be_next;
            if_rdata_reg  <= if_rdata_next;
            dm_rdata_reg  <= dm_rdata_next;
            if_ack_reg    <= if_ack_next;
            dm_ack_reg    <= dm_ack_next;
            err_reg       <= err_next;
            burst_reg     <= burst_next;
            tmo_reg       <= tmo_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_be_next    = mem_be_reg;
        if_rdata_next  = if_rdata_reg;
        dm_rdata_next  = dm_rdata_reg;
        if_ack_next    = 1'b0;
        dm_ack_next    = 1'b0;
        err_next       = err_reg;
        burst_next     = burst_reg;
        tmo_next       = tmo_reg;
        grant_dm       = 1'b0;
        grant_if       = 1'b0;
        done_ok        = 1'b0;
        done_tmo       = 1'b0;
        resp_data      = '0;

        case (state_reg)
            ST_IDLE: begin
                // DM wins unless IF has already waited out a full DM burst.
                if (dm_any && !(bus.if_req && burst_reg == BURST_W'(MAX_DM_BURST))) begin
                    grant_dm       = 1'b1;
                    state_next     = ST_DACC;
                    mem_addr_next  = bus.dm_addr;
                    mem_wdata_next = bus.dm_wdata;
                    // A request with both rd and wr set is performed as a write
                    // and flagged as an error.
                    mem_we_next    = bus.dm_wr;
                    mem_be_next    = bus.dm_wr ? bus.dm_be : '1;
                    if (bus.dm_rd && bus.dm_wr) begin
                        err_next = 1'b1;
                    end
                end else if (bus.if_req) begin
                    grant_if      = 1'b1;
                    state_next    = ST_IFETCH;
                    mem_addr_next = bus.if_addr;
                    mem_we_next   = 1'b0;
                    mem_be_next   = '1;
                end
                tmo_next = '0;
            end
            ST_IFETCH, ST_DACC: begin
                // mem_ready wins over the timeout in the final allowed cycle.
                if (bus.mem_ready) begin
                    done_ok = 1'b1;
                end else if (tmo_reg == TMO_W'(TIMEOUT - 1)) begin
                    done_tmo = 1'b1;
                end

                if (done_ok || done_tmo) begin
                    resp_data  = done_ok ? bus.mem_rdata : '0;
                    state_next = ST_IDLE;
                    tmo_next   = '0;
                    if (state_reg == ST_IFETCH) begin
                        if_ack_next   = 1'b1;
                        if_rdata_next = resp_data;
                    end else begin
                        dm_ack_next   = 1'b1;
                        dm_rdata_next = resp_data;
                    end
                    if (done_tmo) begin
                        err_next = 1'b1;
                    end
                end else begin
                    tmo_next = tmo_reg + TMO_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // The counter only counts DM grants that overtook a waiting fetch.
        if (!bus.if_req || grant_if) begin
            burst_next = '0;
        end else if (grant_dm) begin
            burst_next = burst_reg + BURST_W'(1);
        end
    end

    // mem_req follows the state register, so reset drops it immediately.
    assign bus.mem_req   = (state_reg != ST_IDLE);
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.mem_be    = mem_be_reg;
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.if_ack    = if_ack_reg;
    assign bus.dm_rdata  = dm_rdata_reg;
    assign bus.dm_ack    = dm_ack_reg;
    assign bus.err_o     = err_reg;
    assign bus.stall_o   = (bus.if_req & ~if_ack_reg) | (dm_any & ~dm_ack_reg);
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXB = 2;
    localparam int TO   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DM_BURST(MAXB), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.dm_rd     = 1'b0;
        bus.dm_wr     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.dm_be     = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    // ---------------- transaction-level reference model ----------------
    // One memory job at a time. A job is started by the grant rule, and it
    // finishes on mem_ready or after TO unanswered cycles.
    logic          m_busy, m_dm, m_we, m_err, m_new;
    logic          m_if_ack, m_dm_ack;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_if_rdata, m_dm_rdata;
    logic [BW-1:0] m_be;
    int            m_wait, m_burst, mem_cnt, mem_lat, ntxn;

    task automatic model_reset();
        m_busy = 0; m_dm = 0; m_we = 0; m_err = 0; m_new = 0;
        m_if_ack = 0; m_dm_ack = 0;
        m_addr = '0; m_wdata = '0; m_be = '0;
        m_if_rdata = '0; m_dm_rdata = '0;
        m_wait = 0; m_burst = 0; mem_cnt = 0; mem_lat = 0;
    endtask

    task automatic model_finish(input logic [DW-1:0] data);
        if (m_dm) begin m_dm_ack = 1; m_dm_rdata = data; end
        else      begin m_if_ack = 1; m_if_rdata = data; end
        m_busy = 0;
    endtask

    // Advance the model across one rising edge, using the inputs now driven.
    task automatic model_step();
        logic was_busy;
        was_busy = m_busy;
        m_if_ack = 0;
        m_dm_ack = 0;
        if (was_busy) begin
            if (bus.mem_ready) model_finish(bus.mem_rdata);
            else if (m_wait + 1 >= TO) begin model_finish('0); m_err = 1; end
            else m_wait++;
        end else if ((bus.dm_rd || bus.dm_wr) && !(bus.if_req && m_burst == MAXB)) begin
            m_busy = 1; m_dm = 1; m_new = 1; m_wait = 0;
            m_addr = bus.dm_addr; m_wdata = bus.dm_wdata; m_we = bus.dm_wr;
            m_be = bus.dm_wr ? bus.dm_be : {BW{1'b1}};
            if (bus.dm_rd && bus.dm_wr) m_err = 1;
            if (bus.if_req) m_burst++;
        end else if (bus.if_req) begin
            m_busy = 1; m_dm = 0; m_new = 1; m_wait = 0;
            m_addr = bus.if_addr; m_we = 0; m_be = {BW{1'b1}};
            m_burst = 0;
        end
        if (!bus.if_req) m_burst = 0;
    endtask

    task automatic new_if();
        bus.if_req  = 1'b1;
        bus.if_addr = $urandom;
    endtask

    task automatic new_dm();
        int r;
        r = $urandom_range(0, 63);
        bus.dm_rd    = (r < 28) || (r == 63);
        bus.dm_wr    = (r >= 28);
        bus.dm_addr  = $urandom;
        bus.dm_wdata = $urandom;
        bus.dm_be    = BW'($urandom);
    endtask

    initial begin
        int nack, last, r;
        idle_inputs();
        model_reset();
        ntxn = 0;

        // ---- reset state ----
        repeat (3) cyc();
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_mem_be", bus.mem_be, 0);
        chk("rst_if_ack", bus.if_ack, 0);
        chk("rst_dm_ack", bus.dm_ack, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_dm_rdata", bus.dm_rdata, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_stall", bus.stall_o, 0);
        rst_n = 1'b1;

        // ---- 1: single fetch, zero wait state ----
        bus.if_req = 1; bus.if_addr = 32'h100; bus.mem_ready = 1; bus.mem_rdata = 32'hA5A5_0001;
        #1 chk("t1_stall_c0", bus.stall_o, 1);
        cyc();
        chk("t1_mem_req_c1", bus.mem_req, 1);
        chk("t1_mem_addr_c1", bus.mem_addr, 32'h100);
        chk("t1_mem_we_c1", bus.mem_we, 0);
        chk("t1_mem_be_c1", bus.mem_be, 4'hF);
        chk("t1_if_ack_c1", bus.if_ack, 0);
        cyc();
        chk("t1_if_ack_c2", bus.if_ack, 1);
        chk("t1_if_rdata_c2", bus.if_rdata, 32'hA5A5_0001);
        chk("t1_mem_req_c2", bus.mem_req, 0);
        chk("t1_stall_c2", bus.stall_o, 0);
        $display("txn dir1: IF addr=00000100 rdata=%h", bus.if_rdata);
        bus.if_req = 0; bus.mem_rdata = 32'h0;
        cyc();
        chk("t1_if_ack_c3", bus.if_ack, 0);
        chk("t1_if_rdata_hold", bus.if_rdata, 32'hA5A5_0001);

        // ---- 2: write with 3 wait states ----
        bus.dm_wr = 1; bus.dm_addr = 32'h2000; bus.dm_wdata = 32'hDEAD_BEEF; bus.dm_be = 4'b0011;
        bus.mem_ready = 0;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            chk("t2_mem_req", bus.mem_req, 1);
            chk("t2_mem_we", bus.mem_we, 1);
            chk("t2_mem_addr", bus.mem_addr, 32'h2000);
            chk("t2_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            chk("t2_mem_be", bus.mem_be, 4'b0011);
            chk("t2_dm_ack_early", bus.dm_ack, 0);
            chk("t2_stall", bus.stall_o, 1);
            if (c == 4) bus.mem_ready = 1;
        end
        cyc();
        chk("t2_dm_ack", bus.dm_ack, 1);
        chk("t2_mem_req_done", bus.mem_req, 0);
        chk("t2_stall_ack", bus.stall_o, 0);
        $display("txn dir2: DM write addr=00002000 data=deadbeef");
        bus.dm_wr = 0; bus.mem_ready = 0;
        cyc();
        chk("t2_dm_ack_once", bus.dm_ack, 0);

        // ---- 3: both held, grant order DM,DM,IF repeating ----
        bus.if_req = 1; bus.if_addr = 32'h3000; bus.dm_rd = 1; bus.dm_addr = 32'h4000;
        bus.mem_ready = 1;
        nack = 0; last = 0;
        for (int c = 1; c <= 40 && nack < 6; c++) begin
            cyc();
            if (bus.if_ack || bus.dm_ack) begin
                chk("t3_order", bus.dm_ack, (nack % 3) != 2);
                chk("t3_single_ack", bus.if_ack & bus.dm_ack, 0);
                chk("t3_spacing", c - last, 2);
                $display("txn dir3.%0d: %s", nack, bus.dm_ack ? "DM" : "IF");
                last = c;
                nack++;
                if (nack == 6) begin bus.if_req = 0; bus.dm_rd = 0; end
            end
        end
        chk("t3_ack_count", nack, 6);
        bus.mem_ready = 0;
        cyc();

        // ---- 4: timeout ----
        bus.if_req = 1; bus.if_addr = 32'h5000; bus.mem_rdata = 32'hFFFF_FFFF;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            chk("t4_mem_req", bus.mem_req, 1);
            chk("t4_if_ack_early", bus.if_ack, 0);
        end
        cyc();
        chk("t4_if_ack", bus.if_ack, 1);
        chk("t4_if_rdata_zero", bus.if_rdata, 0);
        chk("t4_err", bus.err_o, 1);
        chk("t4_mem_req_done", bus.mem_req, 0);
        $display("txn dir4: IF addr=00005000 timeout");
        bus.if_req = 0;
        repeat (3) cyc();
        chk("t4_err_sticky", bus.err_o, 1);

        // ---- 5: async reset mid-wait ----
        bus.dm_rd = 1; bus.dm_addr = 32'h6000;
        cyc();
        cyc();
        chk("t5_mem_req_pre", bus.mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_mem_req_async", bus.mem_req, 0);
        chk("t5_err_cleared", bus.err_o, 0);
        chk("t5_mem_addr_cleared", bus.mem_addr, 0);
        bus.dm_rd = 0;
        cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("t5_no_ack", bus.dm_ack | bus.if_ack, 0);
            chk("t5_idle", bus.mem_req, 0);
        end
        bus.if_req = 1; bus.if_addr = 32'h7000; bus.mem_ready = 1; bus.mem_rdata = 32'h1234_5678;
        cyc();
        chk("t5_new_req", bus.mem_req, 1);
        chk("t5_new_addr", bus.mem_addr, 32'h7000);
        cyc();
        chk("t5_new_ack", bus.if_ack, 1);
        chk("t5_new_rdata", bus.if_rdata, 32'h1234_5678);
        $display("txn dir5: IF addr=00007000 rdata=%h", bus.if_rdata);
        bus.if_req = 0;
        cyc();

        // ---- 6: rd and wr together ----
        bus.dm_rd = 1; bus.dm_wr = 1; bus.dm_addr = 32'h8000;
        bus.dm_wdata = 32'h0BAD_F00D; bus.dm_be = 4'b1100;
        chk("t6_err_before", bus.err_o, 0);
        cyc();
        chk("t6_mem_we", bus.mem_we, 1);
        chk("t6_mem_be", bus.mem_be, 4'b1100);
        chk("t6_mem_wdata", bus.mem_wdata, 32'h0BAD_F00D);
        chk("t6_err", bus.err_o, 1);
        cyc();
        chk("t6_dm_ack", bus.dm_ack, 1);
        $display("txn dir6: DM rd+wr addr=00008000");
        bus.dm_rd = 0; bus.dm_wr = 0;
        cyc();

        // ---- randomized traffic against the reference model ----
        do_reset();
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            cyc();
            chk("r_mem_req", bus.mem_req, m_busy);
            chk("r_if_ack", bus.if_ack, m_if_ack);
            chk("r_dm_ack", bus.dm_ack, m_dm_ack);
            chk("r_if_rdata", bus.if_rdata, m_if_rdata);
            chk("r_dm_rdata", bus.dm_rdata, m_dm_rdata);
            chk("r_err", bus.err_o, m_err);
            if (m_busy) begin
                chk("r_mem_addr", bus.mem_addr, m_addr);
                chk("r_mem_we", bus.mem_we, m_we);
                chk("r_mem_be", bus.mem_be, m_be);
                if (m_we) chk("r_mem_wdata", bus.mem_wdata, m_wdata);
            end
            if (m_if_ack || m_dm_ack) begin
                ntxn++;
                $display("txn %0d: %s addr=%h we=%0d rdata=%h", ntxn, m_dm ? "DM" : "IF",
                         m_addr, m_we, m_dm ? m_dm_rdata : m_if_rdata);
            end
            if (i % 300 == 299) begin
                do_reset();
                model_reset();
                continue;
            end

            // fetch requester
            if (bus.if_req) begin
                if (m_if_ack) begin
                    if ($urandom_range(0, 3) != 0) new_if(); else bus.if_req = 0;
                end else if ($urandom_range(0, 31) == 0) bus.if_req = 0;
            end else if ($urandom_range(0, 2) == 0) new_if();

            // load/store requester
            if (bus.dm_rd || bus.dm_wr) begin
                if (m_dm_ack) begin
                    if ($urandom_range(0, 3) != 0) new_dm();
                    else begin bus.dm_rd = 0; bus.dm_wr = 0; end
                end else if ($urandom_range(0, 31) == 0) begin bus.dm_rd = 0; bus.dm_wr = 0; end
            end else if ($urandom_range(0, 2) == 0) new_dm();

            // memory: wait states chosen per job, occasionally never ready
            bus.mem_rdata = $urandom;
            if (m_busy) begin
                if (m_new) begin
                    r = $urandom_range(0, 15);
                    mem_lat = (r < 7) ? 0 : (r < 10) ? 1 : (r < 12) ? 2 : (r < 14) ? 3 : 100;
                    mem_cnt = 0;
                    m_new = 0;
                end
                bus.mem_ready = (mem_cnt == mem_lat);
                mem_cnt++;
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end

            #1;
            chk("r_stall", bus.stall_o,
                (bus.if_req & ~m_if_ack) | ((bus.dm_rd | bus.dm_wr) & ~m_dm_ack));
            model_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
